// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency data-bus responder over a 64-bit SRAM.
// Define DBUS_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles.
package dbus_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_sram_responder
   import dbus_pkg::*;
#(
   parameter int unsigned WORDS   = 4096,
   parameter int unsigned LATENCY = 2,
   parameter logic [63:0] BASE    = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       fault
);
   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   logic [4:0]    r_cnt;
   logic [63:0]   r_addr;
   logic [63:0]   r_wdata;
   logic [7:0]    r_strb;
   logic [2:0]    r_size;
   logic [63:0]   r_rdata;
   logic          r_data_ok;
   logic          r_fault;
   logic [63:0]   mem [WORDS];

   logic          w_idle;
   logic [63:0]   w_addr;
   logic [7:0]    w_strb;
   logic [63:0]   w_wdata;
   logic [63:0]   w_off;
   logic [63:0]   w_word;
   logic [AW-1:0] w_idx;
   logic          w_inrange;
   logic [63:0]   w_merged;
   logic [4:0]    w_load;
   logic          w_to_resp;
   logic          w_unused;

   // Decode the live request while idle, the latched copy otherwise.
   assign w_idle  = (r_state == S_IDLE);
   assign w_addr  = w_idle ? dreq.addr   : r_addr;
   assign w_strb  = w_idle ? dreq.strobe : r_strb;
   assign w_wdata = w_idle ? dreq.data   : r_wdata;

   assign w_off     = w_addr - BASE;
   assign w_word    = w_off >> 3;
   assign w_idx     = w_word[AW-1:0];
   assign w_inrange = (w_addr >= BASE) && (w_word < 64'(WORDS));
   assign w_unused  = ^r_size;

   always_comb begin
      w_merged = mem[w_idx];
      for (int i = 0; i < 8; i++) begin
         if (w_strb[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
      end
   end

`ifdef DBUS_RAND_DELAY_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (reset) r_lfsr <= 16'hACE1;
      else       r_lfsr <= {r_lfsr[14:0],
                            r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   assign w_load = 5'(LATENCY - 1) + {3'b000, r_lfsr[1:0]};
`else
   assign w_load = 5'(LATENCY - 1);
`endif

   assign w_to_resp = (w_idle && dreq.valid && (w_load == 5'd0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 5'd1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_size    <= '0;
         r_rdata   <= '0;
         r_data_ok <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_data_ok <= w_to_resp;
         r_fault   <= w_to_resp && !w_inrange;
         if (w_to_resp) r_rdata <= w_inrange ? w_merged : 64'd0;
         unique case (r_state)
            S_IDLE: begin
               if (dreq.valid) begin
                  r_addr  <= dreq.addr;
                  r_wdata <= dreq.data;
                  r_strb  <= dreq.strobe;
                  r_size  <= dreq.size;
                  r_cnt   <= w_load;
                  r_state <= (w_load == 5'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 5'd1;
               if (r_cnt == 5'd1) r_state <= S_RESP;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Commit on the RESP edge; a reset on that edge discards the write.
   always_ff @(posedge clk) begin
      if (!reset && (r_state == S_RESP) && w_inrange && (|r_strb))
         mem[w_idx] <= w_merged;
   end

   always_comb begin
      dresp.addr_ok = w_idle && dreq.valid && !reset;
      dresp.data_ok = r_data_ok;
      dresp.data    = r_rdata;
   end

   assign fault = r_fault;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: randomized self-checking bench against a word/byte
// memory model; latency window widens to 2..5 when DBUS_RAND_DELAY_EN is set.
module tb_dbus_sram_responder;
   import dbus_pkg::*;

   localparam int unsigned WORDS   = 4096;
   localparam int unsigned LATENCY = 2;
   localparam logic [63:0] BASE    = 64'h8000_0000;
`ifdef DBUS_RAND_DELAY_EN
   localparam int LAT_LO = LATENCY;
   localparam int LAT_HI = LATENCY + 3;
`else
   localparam int LAT_LO = LATENCY;
   localparam int LAT_HI = LATENCY;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   dbus_req_t  dreq = '0;
   dbus_resp_t dresp;
   logic       fault;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] m [64];

   dbus_sram_responder #(
      .WORDS(WORDS), .LATENCY(LATENCY), .BASE(BASE)
   ) dut (
      .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] merge(input logic [63:0] old,
         input logic [7:0] s, input logic [63:0] d);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // One bus transaction; dreq is scrambled right after acceptance.
   task automatic do_req(input logic [63:0] a, input logic [7:0] s,
         input logic [63:0] d, output logic [63:0] rd, output logic f,
         output int lat, output logic wide, output logic to);
      int n;
      rd = '0; f = 1'b0; lat = 0; wide = 1'b0; to = 1'b0;
      @(negedge clk);
      dreq = '{valid:1'b1, addr:a, size:3'd3, strobe:s, data:d};
      #1;
      n = 0;
      while (!dresp.addr_ok && n < 40) begin
         @(negedge clk); #1; n++;
      end
      if (!dresp.addr_ok) begin
         to = 1'b1; dreq.valid = 1'b0; return;
      end
      @(negedge clk);
      dreq = '{valid:1'b0, addr:{$urandom, $urandom}, size:3'($urandom),
               strobe:8'($urandom), data:{$urandom, $urandom}};
      #1;
      lat = 1;
      while (!dresp.data_ok && lat < 40) begin
         @(negedge clk); #1; lat++;
      end
      if (!dresp.data_ok) begin
         to = 1'b1; return;
      end
      rd = dresp.data; f = fault;
      @(negedge clk); #1;
      wide = dresp.data_ok || fault;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dreq = '{valid:1'b1, addr:BASE, size:3'd3, strobe:8'h00, data:64'h0};
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (dresp.addr_ok !== 1'b0) begin
         n_bad++; $display("FAIL rst_addr_ok: got %b want 0", dresp.addr_ok);
      end
      n_cmp++;
      if (dresp.data_ok !== 1'b0) begin
         n_bad++; $display("FAIL rst_data_ok: got %b want 0", dresp.data_ok);
      end
      n_cmp++;
      if (dresp.data !== 64'd0) begin
         n_bad++; $display("FAIL rst_data: got %h want 0", dresp.data);
      end
      n_cmp++;
      if (fault !== 1'b0) begin
         n_bad++; $display("FAIL rst_fault: got %b want 0", fault);
      end
      dreq.valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      logic [63:0] rd; logic f, wide, to; int lat;
      do_req(BASE + 64'h10, 8'hFF, 64'h1122334455667788, rd, f, lat, wide, to);
      n_cmp++;
      if (to || lat < LAT_LO || lat > LAT_HI) begin
         n_bad++;
         $display("FAIL wr_lat: got %0d (to=%b) want %0d..%0d", lat, to, LAT_LO, LAT_HI);
      end
      n_cmp++;
      if (rd !== 64'h1122334455667788 || f !== 1'b0) begin
         n_bad++; $display("FAIL wr_resp: got %h f=%b want 1122334455667788 f=0", rd, f);
      end
      do_req(BASE + 64'h10, 8'h00, 64'hFFFF, rd, f, lat, wide, to);
      n_cmp++;
      if (to || rd !== 64'h1122334455667788 || f !== 1'b0) begin
         n_bad++; $display("FAIL rd_back: got %h f=%b want 1122334455667788 f=0", rd, f);
      end
      n_cmp++;
      if (wide !== 1'b0) begin
         n_bad++; $display("FAIL rd_width: data_ok got 2 cycles want 1");
      end
   endtask

   task automatic test_strobe_merge();
      logic [63:0] rd; logic f, wide, to; int lat;
      do_req(BASE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, f, lat, wide, to);
      do_req(BASE + 64'h3, 8'h08, 64'h0000_0000_AB00_0000, rd, f, lat, wide, to);
      n_cmp++;
      if (to || rd !== 64'hFFFF_FFFF_ABFF_FFFF) begin
         n_bad++; $display("FAIL merge_wr: got %h want ffffffffabffffff", rd);
      end
      do_req(BASE, 8'h00, 64'h0, rd, f, lat, wide, to);
      n_cmp++;
      if (to || rd !== 64'hFFFF_FFFF_ABFF_FFFF) begin
         n_bad++; $display("FAIL merge_rd: got %h want ffffffffabffffff", rd);
      end
   endtask

   task automatic test_out_of_range();
      logic [63:0] rd, oob [2]; logic [7:0] s; logic f, wide, to; int lat;
      oob[0] = 64'h7FFF_FFF8;
      oob[1] = BASE + 64'(8 * WORDS);
      do_req(BASE + 64'(8 * (WORDS - 1)), 8'hFF, 64'h5A5A_0F0F_C3C3_9696,
             rd, f, lat, wide, to);
      for (int k = 0; k < 4; k++) begin
         s = (k < 2) ? 8'h00 : 8'hFF;
         do_req(oob[k % 2], s, 64'h0123_4567_89AB_CDEF, rd, f, lat, wide, to);
         n_cmp++;
         if (to || rd !== 64'd0 || f !== 1'b1 || wide !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_%0d: got data %h fault %b wide %b want 0 1 0", k, rd, f, wide);
         end
      end
      do_req(BASE, 8'h00, 64'h0, rd, f, lat, wide, to);
      n_cmp++;
      if (rd !== 64'hFFFF_FFFF_ABFF_FFFF) begin
         n_bad++; $display("FAIL oob_word0: got %h want ffffffffabffffff", rd);
      end
      do_req(BASE + 64'(8 * (WORDS - 1)), 8'h00, 64'h0, rd, f, lat, wide, to);
      n_cmp++;
      if (rd !== 64'h5A5A_0F0F_C3C3_9696) begin
         n_bad++; $display("FAIL oob_wordlast: got %h want 5a5a0f0fc3c39696", rd);
      end
   endtask

   task automatic test_abandon();
      logic [63:0] rd; logic f, wide, to; int lat;
      do_req(BASE + 64'd40, 8'hFF, 64'hDEAD, rd, f, lat, wide, to);
      n_cmp++;
      if (to || wide !== 1'b0) begin
         n_bad++; $display("FAIL abandon_pulse: timeout %b wide %b want 0 0", to, wide);
      end
      do_req(BASE + 64'd40, 8'h00, 64'h0, rd, f, lat, wide, to);
      n_cmp++;
      if (rd !== 64'hDEAD) begin
         n_bad++; $display("FAIL abandon_rd: got %h want dead", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd; logic f, wide, to, seen; int lat, n;
      do_req(BASE + 64'd56, 8'hFF, 64'h0, rd, f, lat, wide, to);
      @(negedge clk);
      dreq = '{valid:1'b1, addr:BASE + 64'd56, size:3'd3, strobe:8'hFF, data:64'h1};
      #1;
      n = 0;
      while (!dresp.addr_ok && n < 40) begin
         @(negedge clk); #1; n++;
      end
      @(negedge clk);
      dreq.valid = 1'b0;
      reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         reset = 1'b0;
         #1;
         if (dresp.data_ok || fault) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_pulse: data_ok got 1 want 0");
      end
      do_req(BASE + 64'd56, 8'h00, 64'h0, rd, f, lat, wide, to);
      n_cmp++;
      if (to || rd !== 64'h0) begin
         n_bad++; $display("FAIL rstmid_rd: got %h want 0", rd);
      end
   endtask

   task automatic test_random();
      logic [63:0] rd, a, d, exp; logic [7:0] s; logic f, wide, to, oob;
      int lat, w;
      for (int i = 0; i < 64; i++) begin
         m[i] = {$urandom, $urandom};
         do_req(BASE + 64'(8 * i), 8'hFF, m[i], rd, f, lat, wide, to);
      end
      for (int i = 0; i < 300; i++) begin
         w = int'($urandom_range(0, 63));
         d = {$urandom, $urandom};
         s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         oob = ($urandom_range(0, 7) == 0);
         if (!oob) begin
            a = BASE + 64'(8 * w) + 64'($urandom_range(0, 7));
            exp = merge(m[w], s, d);
            m[w] = exp;
         end else begin
            a = ($urandom_range(0, 1) == 0) ? BASE - 64'($urandom_range(1, 5000))
                : BASE + 64'(8 * WORDS) + 64'($urandom_range(0, 5000));
            exp = 64'd0;
         end
         do_req(a, s, d, rd, f, lat, wide, to);
         n_cmp++;
         if (to || rd !== exp || f !== oob || wide !== 1'b0 ||
             lat < LAT_LO || lat > LAT_HI) begin
            n_bad++;
            $display("FAIL rand_%0d: addr %h got %h f=%b lat=%0d wide=%b want %h f=%b",
                     i, a, rd, f, lat, wide, exp, oob);
         end
      end
   endtask

   task automatic test_held_valid();
      int acc_cyc, done, lat, cyc;
      logic pend, prev_dok, need_new, abort;
      logic [5:0] w;
      logic [63:0] exp;
      pend = 1'b0; prev_dok = 1'b0; need_new = 1'b0; abort = 1'b0;
      done = 0; acc_cyc = 0; exp = '0;
      w = 6'($urandom);
      for (cyc = 0; cyc < 8000 && done < 1000 && !abort; cyc++) begin
         @(negedge clk);
         if (cyc == 0)
            dreq = '{valid:1'b1, addr:BASE + 64'(8 * w), size:3'd3,
                     strobe:8'h00, data:{$urandom, $urandom}};
         if (need_new) begin
            w = 6'($urandom);
            dreq.addr = BASE + 64'(8 * w) + 64'($urandom_range(0, 7));
            need_new = 1'b0;
         end
         #1;
         if (dresp.data_ok) begin
            lat = cyc - acc_cyc;
            n_cmp++;
            if (!pend || lat < LAT_LO || lat > LAT_HI || dresp.data !== exp) begin
               n_bad++;
               $display("FAIL held_resp_%0d: pend=%b lat=%0d data %h want lat %0d..%0d data %h",
                        done, pend, lat, dresp.data, LAT_LO, LAT_HI, exp);
            end
            n_cmp++;
            if (prev_dok || dresp.addr_ok) begin
               n_bad++;
               $display("FAIL held_width_%0d: prev_data_ok=%b addr_ok=%b want 0 0",
                        done, prev_dok, dresp.addr_ok);
            end
            pend = 1'b0;
            done++;
         end else if (pend && (cyc - acc_cyc) > LAT_HI) begin
            n_cmp++; n_bad++;
            $display("FAIL held_timeout: no data_ok after %0d cycles", cyc - acc_cyc);
            abort = 1'b1;
         end
         if (dresp.addr_ok) begin
            n_cmp++;
            if (pend) begin
               n_bad++; $display("FAIL held_double_accept: addr_ok got 2 want 1");
            end
            pend = 1'b1;
            acc_cyc = cyc;
            exp = m[w];
            need_new = 1'b1;
         end
         prev_dok = dresp.data_ok;
      end
      @(negedge clk);
      dreq.valid = 1'b0;
      n_cmp++;
      if (done != 1000) begin
         n_bad++; $display("FAIL held_count: got %0d responses want 1000", done);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_strobe_merge();
      test_out_of_range();
      test_abandon();
      test_reset_mid();
      test_random();
      test_held_valid();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Data-bus responder that sits on the far side of the `dbus_req_t`/`dbus_resp_t` interface driven by the memory stage and its page-table walker. It accepts one request at a time, waits a fixed (optionally randomised) number of cycles, and returns one `data_ok` beat. It also commits strobed byte writes into a 64-bit-wide on-chip SRAM model. The block is the standard simulation and FPGA backing store for load/store and PTE-fetch traffic.

## Interface
- `WORDS`, default 4096: number of 64-bit SRAM words.
- `LATENCY`, default 2: cycles from acceptance to `data_ok`. Legal range is 1..15.
- `BASE`, default 64'h8000_0000: physical address of word 0.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `dreq`  in  `dbus_req_t`  request: valid, addr, size, strobe, data.
- `dresp`  out  `dbus_resp_t`  response: addr_ok, data_ok, data.
- `fault`  out  1  access-fault flag. High only in the `data_ok` cycle of an out-of-range request.

## Operation
- States are IDLE, WAIT and RESP.
- **IDLE**
  - If `dreq.valid` is high, latch addr, strobe, data and size.
  - Pulse `dresp.addr_ok` for this cycle.
  - Load `cnt` with LATENCY-1, plus the extra delay when the macro is enabled.
  - Next state is RESP if `cnt` loads 0, otherwise WAIT.
- **WAIT**: decrement `cnt`. When `cnt` reaches 0, go to RESP.
- **RESP**
  - `dresp.data_ok` is 1 for exactly this cycle. Next state is IDLE.
  - A new request is never accepted in the RESP cycle.
- **Address decode**
  - `idx = (addr - BASE) >> 3`.
  - The request is in range iff `addr >= BASE` and `idx < WORDS`.
  - `addr[2:0]` and `size` are ignored for indexing. The requester has already shifted strobe and data into lane position.
- **Write commit**
  - Happens on the RESP clock edge, and only if in range.
  - For each i in 0..7 with `strobe[i]` set, `mem[idx][8i+:8] <= data[8i+:8]`.
  - A zero strobe means a read, which includes PTE fetches (MSIZE8, strobe 0).
- **Read data**
  - `dresp.data` is the full aligned 64-bit word, after merging the write bytes of this request.
  - The requester performs the shift and extension.
  - Out of range: `dresp.data = 0`, no write, `fault = 1` during RESP.
- **Abandonment**
  - Once accepted, a request always completes and its write commits exactly once, even if `dreq.valid` drops or `dreq` changes before RESP (pipeline flush).
  - The latched copy is used throughout, never live `dreq`.

## Timing
- Reset values: state IDLE, `cnt` 0, `dresp.addr_ok` 0, `dresp.data_ok` 0, `dresp.data` 0, `fault` 0.
- SRAM contents are not cleared by reset.
- All outputs are registered. `addr_ok` is the exception: it is combinational from `dreq.valid` in IDLE.
- Request accepted at edge t means `data_ok` is high during cycle t+LATENCY (no random delay).
- Back-to-back throughput: a held-valid requester sees acceptances every LATENCY+1 cycles.
- Reset asserted in WAIT or RESP:
  - the pending request is discarded with no write commit;
  - `data_ok` and `fault` are forced low in the next cycle.
- `dreq.valid` high in the same cycle as RESP is ignored. It is sampled again in the following IDLE cycle.

## Configuration
- `DBUS_RAND_DELAY_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - At acceptance, `lfsr[1:0]` (0..3) extra wait cycles are added to LATENCY-1.
  - The LFSR is for stall-path coverage in the memory stage.
- Not defined: the LFSR is absent and latency is exactly LATENCY.

## Test plan
- Write, then read back (LATENCY=2, macro off):
  - Write addr 8000_0010, strobe FF, data 1122334455667788: `data_ok` 2 cycles after acceptance.
  - Then read with strobe 0 at the same address: data 1122334455667788.
- Byte strobe merge:
  - Preload word 0 with FFFF_FFFF_FFFF_FFFF.
  - Write addr 8000_0003, strobe 08, data 0000_0000_AB00_0000.
  - Read returns FFFF_FFFF_ABFF_FFFF.
- Out of range: read addr 7FFF_FFF8 and read at BASE+8*WORDS. Each returns data 0 with `fault`=1 for one cycle. A write to either address leaves memory unchanged.
- Abandonment:
  - Accept a write of 0xDEAD to word 5, then deassert `dreq.valid` in the next cycle.
  - `data_ok` still pulses. Word 5 reads 0xDEAD, written exactly once.
- Reset mid-request: assert `reset` during WAIT of a write of 0x1 to word 7 (old value 0x0). `data_ok` never pulses and word 7 still reads 0x0.
- Macro on: 1000 held-valid reads.
  - Every latency falls in 2..5.
  - Each `data_ok` is exactly one cycle wide.
  - No two `addr_ok` pulses occur without an intervening `data_ok`.
